// File: rtl/assoc_sram_if.sv
// assoc_sram_if -- request/response bus for the associative table.
//   Request : req_valid, req_ready, req_we, req_addr, req_wdata, req_be
//   Response: rsp_valid, rsp_ready, rsp_rdata, rsp_hit, rsp_err
// The master modport drives requests and accepts responses.
// The slave modport (the table) accepts requests and drives responses.
interface assoc_sram_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_hit;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_hit, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_hit, rsp_err
  );
endinterface

// File: rtl/assoc_sram.sv
// assoc_sram -- small associative {tag, data} table searched linearly.
// Entries 0..count-1 are valid and packed; entries are only removed by reset.
// Each request is searched one entry per cycle (lowest index wins). Writes
// merge bytes on a hit, allocate the next free slot on a miss, or report an
// error when the table is full.
// Ports:
//   clk    - clock, all state on posedge
//   rst_n  - asynchronous active-low reset
//   bus    - assoc_sram_if.slave request/response bus
//   count  - number of valid entries (committed)
//   full   - count == DEPTH
module assoc_sram #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 512,
  parameter logic [DATA_W-1:0] MISS_DATA = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  assoc_sram_if.slave            bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int BW = DATA_W / 8;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;

  logic [ADDR_W-1:0] tag_mem_r  [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];

  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [BW-1:0]     be_r;
  logic [CW-1:0]     idx_r;
  logic [CW-1:0]     count_r;
  logic              full_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_hit_r;
  logic              rsp_err_r;

  logic              accept_s;
  logic [ADDR_W-1:0] cur_tag_s;
  logic [DATA_W-1:0] cur_data_s;
  logic              match_s;
  logic              last_s;
  logic              hit_done_s;
  logic              miss_done_s;
  logic [DATA_W-1:0] merged_s;
  logic [DATA_W-1:0] alloc_s;

  // Byte-lane merge: lanes with be set take new_v, the rest keep old_v.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [BW-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < BW; i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = new_v[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_v[i*8 +: 8];
      end
    end
    return res;
  endfunction

  // Search datapath: compare the entry under idx_r against the latched tag.
  always_comb begin
    accept_s   = bus.req_valid && req_ready_r;
    cur_tag_s  = tag_mem_r[idx_r[IW-1:0]];
    cur_data_s = data_mem_r[idx_r[IW-1:0]];
    match_s    = (idx_r < count_r) && (cur_tag_s == addr_r);
    // Also true for an empty table, giving the single empty search cycle.
    last_s     = ((idx_r + ONE_C) >= count_r);
    merged_s   = merge_bytes(cur_data_s, wdata_r, be_r);
    alloc_s    = merge_bytes({DATA_W{1'b0}}, wdata_r, be_r);
  end

  // Next-state logic and search outcome strobes.
  always_comb begin
    state_next_s = state_r;
    hit_done_s   = 1'b0;
    miss_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_SEARCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (match_s) begin
          state_next_s = ST_RESP;
          hit_done_s   = 1'b1;
        end else if (last_s) begin
          state_next_s = ST_RESP;
          miss_done_s  = 1'b1;
        end else begin
          state_next_s = ST_SEARCH;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Entry storage; not reset because count_r == 0 invalidates every entry.
  // A reset mid-operation forces state_r to IDLE, so nothing commits.
  always_ff @(posedge clk) begin
    if ((state_r == ST_SEARCH) && we_r) begin
      if (hit_done_s) begin
        data_mem_r[idx_r[IW-1:0]] <= merged_s;
      end else if (miss_done_s && !full_r) begin
        tag_mem_r[count_r[IW-1:0]]  <= addr_r;
        data_mem_r[count_r[IW-1:0]] <= alloc_s;
      end
    end
  end

  // Request latch, search index, occupancy and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      be_r        <= '0;
      idx_r       <= '0;
      count_r     <= '0;
      full_r      <= 1'b0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_hit_r   <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_next_s == ST_IDLE);
      rsp_valid_r <= (state_next_s == ST_RESP);
      if (accept_s) begin
        we_r    <= bus.req_we;
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
        be_r    <= bus.req_be;
        idx_r   <= '0;
      end
      if ((state_r == ST_SEARCH) && !match_s && !last_s) begin
        idx_r <= idx_r + ONE_C;
      end
      if ((state_r == ST_SEARCH) && hit_done_s) begin
        rsp_hit_r   <= 1'b1;
        rsp_err_r   <= 1'b0;
        rsp_rdata_r <= we_r ? merged_s : cur_data_s;
      end
      if ((state_r == ST_SEARCH) && miss_done_s) begin
        rsp_hit_r <= 1'b0;
        if (!we_r) begin
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= MISS_DATA;
        end else if (full_r) begin
          rsp_err_r   <= 1'b1;
          rsp_rdata_r <= '0;
        end else begin
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= alloc_s;
          count_r     <= count_r + ONE_C;
          full_r      <= ((count_r + ONE_C) == DEPTH_C);
        end
      end
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_hit   = rsp_hit_r;
  assign bus.rsp_err   = rsp_err_r;
  assign count         = count_r;
  assign full          = full_r;

endmodule

// File: tb/tb_assoc_sram.sv
// tb_assoc_sram -- scoreboard bench for assoc_sram (DEPTH=4).
// A reference model predicts each response (data, hit, err, latency, count,
// full) when the request is accepted; the prediction is queued and compared
// when the DUT raises rsp_valid.
module tb_assoc_sram;
  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 4;
  localparam int          CW     = 3;
  localparam logic [31:0] MISS   = 32'hBADC_0FFE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  assoc_sram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic [CW-1:0] count;
  logic          full;

  assoc_sram #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MISS_DATA(MISS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .count(count), .full(full)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    logic        err;
    int          lat;
    int          cnt;
    logic        full;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_tag  [DEPTH];
  logic [31:0] m_data [DEPTH];
  int          m_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference behaviour of one request; updates the model state.
  task automatic model_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output exp_t e);
    int k;
    logic [31:0] nd;
    k = -1;
    for (int i = 0; i < m_cnt; i++) if (k < 0 && m_tag[i] == addr) k = i;
    e.err = 1'b0;
    if (k >= 0) begin
      e.hit = 1'b1;
      e.lat = 2 + k;
      if (we) for (int b = 0; b < 4; b++) if (be[b]) m_data[k][b*8 +: 8] = wdata[b*8 +: 8];
      e.rdata = m_data[k];
    end else begin
      e.hit = 1'b0;
      e.lat = (m_cnt == 0) ? 2 : 1 + m_cnt;
      if (!we) begin
        e.rdata = MISS;
      end else if (m_cnt == DEPTH) begin
        e.err   = 1'b1;
        e.rdata = 32'h0;
      end else begin
        nd = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) nd[b*8 +: 8] = wdata[b*8 +: 8];
        m_tag[m_cnt]  = addr;
        m_data[m_cnt] = nd;
        m_cnt++;
        e.rdata = nd;
      end
    end
    e.cnt  = m_cnt;
    e.full = (m_cnt == DEPTH);
  endtask

  // Issue one request; hold > 0 keeps rsp_ready low for that many RESP cycles.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold);
    exp_t e;
    int   g;
    int   t_acc;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.rsp_ready = (hold == 0);
    g = 0;
    while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) begin
      check("req_ready_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    model_req(we, addr, wdata, be, e);
    sb_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    g = 0;
    while (!bus.rsp_valid && g < 50) begin @(negedge clk); g++; end
    e = sb_q.pop_front();
    if (g >= 50) begin
      check("rsp_valid_timeout", 64'd0, 64'd1);
      return;
    end
    check("latency", cyc - t_acc, e.lat);
    check("rdata", bus.rsp_rdata, e.rdata);
    check("hit", bus.rsp_hit, e.hit);
    check("err", bus.rsp_err, e.err);
    check("count", count, e.cnt);
    check("full", full, e.full);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        check("stall_req_ready", bus.req_ready, 1'b0);
        check("stall_rsp_valid", bus.rsp_valid, 1'b1);
        check("stall_rdata", bus.rsp_rdata, e.rdata);
        check("stall_hit", bus.rsp_hit, e.hit);
        @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("post_stall_rsp_valid", bus.rsp_valid, 1'b0);
      check("post_stall_req_ready", bus.req_ready, 1'b1);
    end else begin
      @(negedge clk);
      check("post_rsp_valid", bus.rsp_valid, 1'b0);
    end
  endtask

  // Hold reset for a few cycles, check reset values, release, check ready.
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_count", count, 0);
    check("rst_full", full, 1'b0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    m_cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", bus.req_ready, 1'b1);
  endtask

  // Accept a write miss then reset during its search; it must not commit.
  task automatic abort_req(input logic [31:0] addr);
    int g;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = 32'h5555_AAAA;
    bus.req_be    = 4'hF;
    bus.rsp_ready = 1'b1;
    g = 0;
    while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) check("abort_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("abort_count", count, 0);
    check("abort_rsp_valid", bus.rsp_valid, 1'b0);
    check("abort_req_ready", bus.req_ready, 1'b0);
    m_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release_ready", bus.req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [3:0]  rb;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;

    reset_dut();
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 0);                  // read miss on empty table
    do_req(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0);         // allocate
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 0);                  // read hit
    do_req(1'b1, 32'h100, 32'h0000_1234, 4'h3, 0);         // partial merge -> DEAD1234
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 5);                  // stalled response
    do_req(1'b1, 32'h200, 32'h1122_3344, 4'b1010, 0);      // masked allocate
    do_req(1'b0, 32'h200, 32'h0, 4'h0, 0);                  // hit at index 1
    do_req(1'b1, 32'h300, 32'hFFFF_FFFF, 4'h0, 0);         // be=0 miss allocates zero
    do_req(1'b1, 32'h100, 32'hCAFE_F00D, 4'h0, 0);         // be=0 hit leaves data

    abort_req(32'h400);
    do_req(1'b0, 32'h400, 32'h0, 4'h0, 0);                  // aborted write left nothing
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 0);                  // reset emptied table

    for (int t = 0; t < 4; t++) do_req(1'b1, t, 32'h0101_0101 * (t + 1), 4'hF, 0);
    do_req(1'b1, 32'h9, 32'h1234_5678, 4'hF, 0);           // full -> err
    do_req(1'b0, 32'h3, 32'h0, 4'h0, 0);                    // hit at index 3
    do_req(1'b0, 32'h9, 32'h0, 4'h0, 0);                    // read miss on full table

    for (int i = 0; i < 6; i++) begin
      rd = $urandom;
      rb = 4'($urandom_range(0, 15));
      do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 4)), rd, rb, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
